// File: rtl/fpu_pkg.sv
// Shared FPU normalizer types and widths.
package fpu_pkg;

  localparam int unsigned MANT_W  = 24;
  localparam int unsigned EXP_W   = 8;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;

  typedef enum logic [1:0] {
    StIdle,
    StDetect,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/norm_sequencer_if.sv
// Operand/result handshake bundle for the normalization sequencer.
interface norm_sequencer_if;
  import fpu_pkg::*;

  logic              inValid;
  logic              inReady;
  logic              inCout;
  logic [MANT_W-1:0] inMant;
  logic [EXP_W-1:0]  inExp;
  logic              outValid;
  logic              outReady;
  logic [MANT_W-1:0] outMant;
  logic [EXP_W-1:0]  outExp;
  logic              outZero;
  logic              outOvf;
  logic              outUnf;

  // Sequencer side.
  modport slave (
    input  inValid, inCout, inMant, inExp, outReady,
    output inReady, outValid, outMant, outExp, outZero, outOvf, outUnf
  );

  // Producer/consumer side.
  modport master (
    output inValid, inCout, inMant, inExp, outReady,
    input  inReady, outValid, outMant, outExp, outZero, outOvf, outUnf
  );

endinterface

// File: rtl/lzc24.sv
// Combinational 24-bit leading-zero counter; an all-zero input yields 24.
module lzc24 (
  input  logic [23:0] mant_i,
  output logic [4:0]  count_o
);

  // Priority scan from the MSB down; the first set bit fixes the count.
  always_comb begin
    logic found;
    found   = 1'b0;
    count_o = 5'd24;
    for (int i = 23; i >= 0; i--) begin
      if (!found && mant_i[i]) begin
        count_o = 5'(23 - i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/norm_sequencer.sv
// Multi-cycle mantissa normalizer: carry fix-up, zero detect, and a
// left-shift of at most STEP bits per cycle with exponent adjustment.
module norm_sequencer
  import fpu_pkg::*;
#(
  parameter int unsigned STEP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  norm_sequencer_if.slave  bus,
  output logic             busy
);

  localparam logic [4:0] StepAmt = 5'(STEP);

  state_e            state_q;
  logic [MANT_W-1:0] mant_q;
  logic [EXP_W-1:0]  exp_q;
  logic [4:0]        rem_q;
  logic              cout_q;
  logic              zero_q, ovf_q, unf_q;
  logic              valid_q, ready_q, busy_q;

  logic [4:0]        lz;
  logic [4:0]        amt_c;
  logic              unf_c;
  logic [EXP_W-1:0]  exp_norm;
  logic [EXP_W-1:0]  exp_m1;
  logic [EXP_W-1:0]  exp_inc;
  logic [4:0]        step_c;
  logic [MANT_W-1:0] mant_shl;

  lzc24 u_lzc (
    .mant_i  (mant_q),
    .count_o (lz)
  );

  // Shift amount and final exponent, clamped so the exponent never drops below 1;
  // anything the clamp leaves unshifted becomes a denormal.
  always_comb begin
    exp_m1   = exp_q - 8'd1;
    exp_inc  = exp_q + 8'd1;
    amt_c    = 5'd0;
    unf_c    = 1'b0;
    exp_norm = 8'd0;
    if (exp_q == 8'd0) begin
      unf_c = (lz != 5'd0);
    end else if ({3'b000, lz} > exp_m1) begin
      // exp_m1 < lz <= 23 here, so it fits the 5-bit count.
      amt_c = exp_m1[4:0];
      unf_c = 1'b1;
    end else begin
      amt_c    = lz;
      exp_norm = exp_q - {3'b000, lz};
    end
  end

  // Bounded shifter: only distances 0..STEP are built, not a full barrel.
  always_comb begin
    step_c   = (rem_q > StepAmt) ? StepAmt : rem_q;
    mant_shl = mant_q;
    for (int unsigned i = 1; i <= STEP; i++) begin
      if (step_c == 5'(i)) mant_shl = mant_q << i;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mant_q  <= '0;
      exp_q   <= '0;
      rem_q   <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.inValid) begin
            cout_q  <= bus.inCout;
            mant_q  <= bus.inMant;
            exp_q   <= bus.inExp;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StDetect;
          end
        end
        StDetect: begin
          if (cout_q) begin
            ovf_q   <= (exp_inc == EXP_MAX);
            mant_q  <= (exp_inc == EXP_MAX) ? '0 : {1'b1, mant_q[MANT_W-1:1]};
            exp_q   <= exp_inc;
            valid_q <= 1'b1;
            state_q <= StDone;
          end else if (mant_q == '0) begin
            exp_q   <= '0;
            zero_q  <= 1'b1;
            valid_q <= 1'b1;
            state_q <= StDone;
          end else begin
            exp_q <= exp_norm;
            unf_q <= unf_c;
            rem_q <= amt_c;
            if (amt_c != 5'd0) begin
              state_q <= StShift;
            end else begin
              valid_q <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StShift: begin
          mant_q <= mant_shl;
          rem_q  <= rem_q - step_c;
          if (rem_q == step_c) begin
            valid_q <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (bus.outReady) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.inReady  = ready_q;
  assign bus.outValid = valid_q;
  assign bus.outMant  = mant_q;
  assign bus.outExp   = exp_q;
  assign bus.outZero  = zero_q;
  assign bus.outOvf   = ovf_q;
  assign bus.outUnf   = unf_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_norm_sequencer.sv
// Bench for norm_sequencer: directed table, reset corner cases, random ops
// against an arithmetic reference model.
module tb_norm_sequencer;

  localparam int unsigned STEP = 8;

  typedef struct {
    logic [23:0] mant;
    logic [7:0]  exp;
    logic        zero;
    logic        ovf;
    logic        unf;
    int          lat;
  } res_t;

  typedef struct {
    logic        cout;
    logic [23:0] mant;
    logic [7:0]  exp;
    res_t        want;
    int          hold;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic busy;
  int   n_checks = 0;
  int   n_fail   = 0;

  norm_sequencer_if bus ();

  norm_sequencer #(.STEP(STEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Result straight from the normalization rules; latency counts clock edges
  // starting with the accept edge itself.
  function automatic res_t model(input logic cout, input logic [23:0] m, input logic [7:0] e);
    res_t r;
    int   lz, amt, ei;
    r  = '{mant: 24'h0, exp: 8'h0, zero: 1'b0, ovf: 1'b0, unf: 1'b0, lat: 2};
    ei = int'(e);
    if (cout) begin
      if (ei + 1 == 255) r.ovf = 1'b1;
      else r.mant = (m >> 1) | 24'h800000;
      r.exp = 8'(ei + 1);
    end else if (m == 24'h0) begin
      r.zero = 1'b1;
    end else begin
      lz = 0;
      while (m[23-lz] == 1'b0) lz++;
      if (ei == 0) begin
        amt   = 0;
        r.unf = (lz > 0);
      end else if (lz > ei - 1) begin
        amt   = ei - 1;
        r.unf = 1'b1;
      end else begin
        amt   = lz;
        r.exp = 8'(ei - lz);
      end
      r.mant = m << amt;
      r.lat  = 2 + (amt + int'(STEP) - 1) / int'(STEP);
    end
    return r;
  endfunction

  // Call just after a negedge; the operand is accepted on the next posedge.
  task automatic run_op(input logic cout, input logic [23:0] m, input logic [7:0] e,
                        input res_t x, input int hold, input string tag);
    int lat;
    check({tag, " inReady"}, 64'(bus.inReady), 64'd1);
    bus.inValid = 1'b1;
    bus.inCout  = cout;
    bus.inMant  = m;
    bus.inExp   = e;
    @(posedge clk);
    #1;
    // Junk on the inputs while busy must be ignored.
    bus.inValid = 1'($urandom_range(0, 1));
    bus.inCout  = 1'($urandom);
    bus.inMant  = 24'($urandom);
    bus.inExp   = 8'($urandom);
    lat = 1;
    while (1) begin
      @(negedge clk);
      if (bus.outValid) break;
      lat++;
      if (lat > 60) break;
    end
    check({tag, " latency"}, 64'(lat), 64'(x.lat));
    if (lat > 60) begin
      bus.inValid = 1'b0;
      return;
    end
    check({tag, " outMant"}, 64'(bus.outMant), 64'(x.mant));
    check({tag, " outExp"},  64'(bus.outExp),  64'(x.exp));
    check({tag, " flags zero/ovf/unf"}, 64'({bus.outZero, bus.outOvf, bus.outUnf}),
          64'({x.zero, x.ovf, x.unf}));
    check({tag, " busy"}, 64'(busy), 64'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, " hold result"},
            64'({bus.outValid, bus.inReady, bus.outMant, bus.outExp,
                 bus.outZero, bus.outOvf, bus.outUnf}),
            64'({1'b1, 1'b0, x.mant, x.exp, x.zero, x.ovf, x.unf}));
    end
    // Release with a pending operand: it must not be taken in the same edge.
    bus.outReady = 1'b1;
    bus.inValid  = 1'b1;
    @(posedge clk);
    #1;
    bus.outReady = 1'b0;
    bus.inValid  = 1'b0;
    @(negedge clk);
    check({tag, " release idle"}, 64'({bus.outValid, bus.inReady, busy}), 64'({1'b0, 1'b1, 1'b0}));
  endtask

  vec_t tbl [11];

  initial begin
    res_t        r;
    logic        c;
    logic [23:0] m;
    logic [7:0]  e;
    int          sh;

    tbl[0]  = '{1'b0, 24'h000100, 8'd100, '{24'h800000, 8'd85,  1'b0, 1'b0, 1'b0, 4}, 5};
    tbl[1]  = '{1'b1, 24'h000002, 8'd254, '{24'h000000, 8'd255, 1'b0, 1'b1, 1'b0, 2}, 0};
    tbl[2]  = '{1'b0, 24'h000001, 8'd5,   '{24'h000010, 8'd0,   1'b0, 1'b0, 1'b1, 3}, 1};
    tbl[3]  = '{1'b0, 24'h000000, 8'd77,  '{24'h000000, 8'd0,   1'b1, 1'b0, 1'b0, 2}, 0};
    tbl[4]  = '{1'b1, 24'hFFFFFF, 8'd10,  '{24'hFFFFFF, 8'd11,  1'b0, 1'b0, 1'b0, 2}, 0};
    tbl[5]  = '{1'b0, 24'h800000, 8'd50,  '{24'h800000, 8'd50,  1'b0, 1'b0, 1'b0, 2}, 2};
    tbl[6]  = '{1'b0, 24'h400000, 8'd0,   '{24'h400000, 8'd0,   1'b0, 1'b0, 1'b1, 2}, 0};
    tbl[7]  = '{1'b0, 24'h100000, 8'd1,   '{24'h100000, 8'd0,   1'b0, 1'b0, 1'b1, 2}, 0};
    tbl[8]  = '{1'b0, 24'h000001, 8'd100, '{24'h800000, 8'd77,  1'b0, 1'b0, 1'b0, 5}, 0};
    tbl[9]  = '{1'b0, 24'h080000, 8'd5,   '{24'h800000, 8'd1,   1'b0, 1'b0, 1'b0, 3}, 0};
    tbl[10] = '{1'b1, 24'h000000, 8'd3,   '{24'h800000, 8'd4,   1'b0, 1'b0, 1'b0, 2}, 0};

    bus.inValid  = 1'b0;
    bus.inCout   = 1'b0;
    bus.inMant   = '0;
    bus.inExp    = '0;
    bus.outReady = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    check("reset state", 64'({bus.inReady, bus.outValid, busy, bus.outMant, bus.outExp,
                               bus.outZero, bus.outOvf, bus.outUnf}),
          64'({1'b1, 1'b0, 1'b0, 24'h0, 8'h0, 3'b000}));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i].cout, tbl[i].mant, tbl[i].exp, tbl[i].want, tbl[i].hold,
             $sformatf("vec%0d", i));
    end

    // Reset while shifting: outputs clear without a clock edge.
    bus.inValid = 1'b1;
    bus.inCout  = 1'b0;
    bus.inMant  = 24'h000001;
    bus.inExp   = 8'd100;
    @(posedge clk);
    #1 bus.inValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("reset mid-shift", 64'({bus.inReady, bus.outValid, busy, bus.outMant, bus.outExp,
                                   bus.outZero, bus.outOvf, bus.outUnf}),
          64'({1'b1, 1'b0, 1'b0, 24'h0, 8'h0, 3'b000}));
    @(negedge clk);
    rst_n = 1'b1;
    run_op(tbl[0].cout, tbl[0].mant, tbl[0].exp, tbl[0].want, 0, "post-reset");

    // Reset while holding a result in DONE.
    bus.inValid = 1'b1;
    bus.inCout  = 1'b1;
    bus.inMant  = 24'h000002;
    bus.inExp   = 8'd254;
    @(posedge clk);
    #1 bus.inValid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("reset mid-done", 64'({bus.inReady, bus.outValid, busy, bus.outMant, bus.outExp,
                                  bus.outZero, bus.outOvf, bus.outUnf}),
          64'({1'b1, 1'b0, 1'b0, 24'h0, 8'h0, 3'b000}));
    @(negedge clk);
    rst_n = 1'b1;
    run_op(tbl[2].cout, tbl[2].mant, tbl[2].exp, tbl[2].want, 0, "post-reset2");

    // Random operands checked against the reference model.
    for (int n = 0; n < 150; n++) begin
      c  = ($urandom_range(0, 7) == 0);
      sh = $urandom_range(0, 24);
      m  = 24'($urandom) >> sh;
      e  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 254));
      r  = model(c, m, e);
      run_op(c, m, e, r, $urandom_range(0, 3), $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
